// File: rtl/bus2pwl.sv
`timescale 1ns/1ps
// Digital code stream to piecewise-linear analog model: each accepted code starts a linear ramp
// over RAM_CYC clocks. out = {value, slope (V/s), start time (s)}, each a 64-bit $realtobits field.
module bus2pwl #(
    parameter int  WIDTH    = 4,
    parameter real vl       = 0.0,
    parameter real vh       = 1.0,
    parameter int  RAMP_CYC = 4,
    parameter real TCLK_NOM = 1e-9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [191:0]     out,
    output logic             busy,
    output logic [WIDTH-1:0] cur_code
);

    typedef enum logic [0:0] {IDLE = 1'b0, RAMP = 1'b1} state_t;

    localparam int unsigned MAX_CODE = (32'd1 << WIDTH) - 32'd1;
    localparam logic [7:0]  RAMP_CNT = 8'(RAMP_CYC);
    localparam real         RAMP_R   = RAMP_CYC;

    state_t           state_r, state_nxt_s;
    logic [7:0]       cnt_r, cnt_nxt_s;
    logic             pend_full_r, pend_full_nxt_s;
    logic [WIDTH-1:0] pend_code_r, pend_code_nxt_s;
    logic [WIDTH-1:0] cur_code_r, cur_code_nxt_s, launch_code_s;
    logic             xfer_s, ramp_end_s, launch_s, settle_s;
    logic             have_edge_r;
    real              prev_edge_r;
    // Value is held as an offset above vl: reals power up at 0.0, so out reads vl before any edge.
    real              dv_r;
    real              slope_r;
    real              time_r;

    function automatic real now_sec();
        return $realtime * 1.0e-9;
    endfunction

    function automatic real code_dv(input logic [WIDTH-1:0] c);
        return real'(c) * (vh - vl) / real'(MAX_CODE);
    endfunction

    function automatic real tclk_now();
        return have_edge_r ? (now_sec() - prev_edge_r) : TCLK_NOM;
    endfunction

    // The slot frees at the ramp-ending edge, so it may be refilled on that same edge.
    assign ramp_end_s = (state_r == RAMP) && (cnt_r == 8'd1);
    assign in_ready   = !pend_full_r || ramp_end_s;
    assign xfer_s     = in_valid && in_ready && !rst;

    // Next-state, pending-slot and ramp-launch decisions.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        pend_full_nxt_s = pend_full_r;
        pend_code_nxt_s = pend_code_r;
        cur_code_nxt_s  = cur_code_r;
        launch_s        = 1'b0;
        settle_s        = 1'b0;
        launch_code_s   = cur_code_r;
        case (state_r)
            IDLE: begin
                if (xfer_s && (in_code == cur_code_r)) begin
                    settle_s = 1'b1;
                end else if (xfer_s) begin
                    launch_s      = 1'b1;
                    launch_code_s = in_code;
                end else begin
                    launch_s = 1'b0;
                end
            end
            RAMP: begin
                if (ramp_end_s && pend_full_r) begin
                    launch_s        = 1'b1;
                    launch_code_s   = pend_code_r;
                    pend_full_nxt_s = xfer_s;
                    pend_code_nxt_s = in_code;
                end else if (ramp_end_s && xfer_s) begin
                    launch_s      = 1'b1;
                    launch_code_s = in_code;
                end else if (ramp_end_s) begin
                    settle_s    = 1'b1;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                    if (xfer_s) begin
                        pend_full_nxt_s = 1'b1;
                        pend_code_nxt_s = in_code;
                    end else begin
                        pend_full_nxt_s = pend_full_r;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (launch_s) begin
            state_nxt_s    = RAMP;
            cnt_nxt_s      = RAMP_CNT;
            cur_code_nxt_s = launch_code_s;
        end else begin
            cur_code_nxt_s = cur_code_r;
        end
    end

    // State registers, period history and the piecewise-linear segment writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            pend_full_r <= 1'b0;
            pend_code_r <= '0;
            cur_code_r  <= '0;
            have_edge_r <= 1'b0;
            prev_edge_r <= 0.0;
            dv_r        <= 0.0;
            slope_r     <= 0.0;
            time_r      <= now_sec();
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pend_full_r <= pend_full_nxt_s;
            pend_code_r <= pend_code_nxt_s;
            cur_code_r  <= cur_code_nxt_s;
            have_edge_r <= 1'b1;
            prev_edge_r <= now_sec();
            // A launch starts from the exact target of the previous ramp, discarding drift.
            if (launch_s) begin
                dv_r    <= code_dv(cur_code_r);
                slope_r <= (code_dv(launch_code_s) - code_dv(cur_code_r)) / (RAMP_R * tclk_now());
                time_r  <= now_sec();
            end else if (settle_s) begin
                dv_r    <= code_dv(cur_code_r);
                slope_r <= 0.0;
                time_r  <= now_sec();
            end else begin
                dv_r    <= dv_r;
            end
        end
    end

    assign out      = {$realtobits(vl + dv_r), $realtobits(slope_r), $realtobits(time_r)};
    assign busy     = (state_r == RAMP);
    assign cur_code = cur_code_r;

endmodule

// File: tb/tb_bus2pwl.sv
`timescale 1ns/1ps
// Self-checking bench for bus2pwl: directed scenarios plus random traffic, compared against a
// ramp-plan model that tracks deadlines by edge number and measures clock periods itself.
module tb_bus2pwl;

    localparam int  WIDTH = 4;
    localparam int  RC    = 4;
    localparam real VL    = 0.0;
    localparam real VH    = 1.5;
    localparam real TNOM  = 1e-9;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         busy;
    logic [3:0]   in_code;
    logic [3:0]   cur_code;
    logic [191:0] out;
    real          half_ns;

    int n_cmp;
    int n_bad;

    // Reference model state
    bit       m_busy, m_have_pend, m_have_prev;
    logic [3:0] m_cur, m_pend;
    int       edge_idx, m_end;
    real      m_val, m_slope, m_t, m_prev, te;

    bus2pwl #(.WIDTH(WIDTH), .vl(VL), .vh(VH), .RAMP_CYC(RC), .TCLK_NOM(TNOM)) dut (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .busy(busy), .cur_code(cur_code)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #(half_ns > 0.0 ? half_ns : 0.5);
            clk = ~clk;
        end
    end

    function automatic real volt(input logic [3:0] c);
        return VL + real'(c) * (VH - VL) / 15.0;
    endfunction

    function automatic real o_val(input logic [191:0] o);
        return $bitstoreal(o[191:128]);
    endfunction

    function automatic real o_slope(input logic [191:0] o);
        return $bitstoreal(o[127:64]);
    endfunction

    function automatic real o_time(input logic [191:0] o);
        return $bitstoreal(o[63:0]);
    endfunction

    task automatic chk_bit(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_real(input string tag, input real obs, input real exp, input real tol);
        logic ok;
        ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: observed %g expected %g", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return !m_have_pend || (m_busy && (edge_idx + 1 == m_end));
    endfunction

    function automatic void model_launch(input logic [3:0] c, input real tclk);
        m_val   = volt(m_cur);
        m_slope = (volt(c) - volt(m_cur)) / (real'(RC) * tclk);
        m_t     = te;
        m_cur   = c;
        m_busy  = 1'b1;
        m_end   = edge_idx + RC;
    endfunction

    function automatic void model_edge(input logic r, input bit acc, input logic [3:0] c);
        real tclk;
        edge_idx++;
        if (r) begin
            m_busy = 1'b0; m_have_pend = 1'b0; m_have_prev = 1'b0; m_cur = 4'd0;
            m_val = VL; m_slope = 0.0; m_t = te;
        end else begin
            tclk = m_have_prev ? (te - m_prev) : TNOM;
            if (m_busy && edge_idx == m_end) begin
                m_val = volt(m_cur); m_slope = 0.0; m_t = te;
                if (m_have_pend) begin
                    model_launch(m_pend, tclk);
                    m_have_pend = acc;
                    m_pend = c;
                end else if (acc) begin
                    model_launch(c, tclk);
                end else begin
                    m_busy = 1'b0;
                end
            end else if (m_busy) begin
                if (acc) begin
                    m_have_pend = 1'b1;
                    m_pend = c;
                end
            end else if (acc) begin
                if (c == m_cur) begin
                    m_val = volt(m_cur); m_slope = 0.0; m_t = te;
                end else begin
                    model_launch(c, tclk);
                end
            end
            m_prev = te;
            m_have_prev = 1'b1;
        end
    endfunction

    // One clock: drive at negedge, update model at posedge, check outputs at next negedge.
    task automatic step(input logic r, input logic v, input logic [3:0] c, output bit acc);
        bit rdy;
        rst = r; in_valid = v; in_code = c;
        rdy = model_ready();
        chk_bit("inputs_known", 32'($isunknown({rst, in_valid, in_code})), 32'd0);
        chk_bit("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk);
        te  = $realtime * 1.0e-9;
        acc = v && rdy && !r;
        model_edge(r, acc, c);
        @(negedge clk);
        chk_bit("busy", 32'(busy), 32'(m_busy));
        chk_bit("cur_code", 32'(cur_code), 32'(m_cur));
        chk_real("out_val", o_val(out), m_val, 1e-9);
        chk_real("out_slope", o_slope(out), m_slope, 1.0 + 1e-6 * (m_slope < 0.0 ? -m_slope : m_slope));
        chk_real("out_time", o_time(out), m_t, 1e-13);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, a);
    endtask

    task automatic do_reset();
        bit a;
        step(1'b1, 1'b0, 4'd0, a);
        step(1'b1, 1'b0, 4'd0, a);
    endtask

    initial begin
        bit acc;
        logic [3:0] q[$];
        n_cmp = 0; n_bad = 0; edge_idx = 0; m_end = 0;
        half_ns = 0.5;
        rst = 1'b1; in_valid = 1'b0; in_code = 4'd0;
        #0.2;
        chk_real("t0_val", o_val(out), VL, 1e-12);
        chk_real("t0_slope", o_slope(out), 0.0, 1e-12);

        // Scenario 1: single ramp to code 10
        do_reset();
        step(1'b0, 1'b1, 4'd10, acc);
        chk_real("s1_slope", o_slope(out), 2.5e8, 1.0);
        idle(2);
        chk_real("s1_mid", o_val(out) + o_slope(out) * (te - o_time(out)), 0.5, 1e-6);
        chk_bit("s1_busy_mid", 32'(busy), 32'd1);
        idle(2);
        chk_real("s1_end_val", o_val(out), 1.0, 1e-12);
        chk_real("s1_end_slope", o_slope(out), 0.0, 1e-12);
        chk_bit("s1_busy_end", 32'(busy), 32'd0);

        // Scenario 2: second code queued during a ramp
        do_reset();
        step(1'b0, 1'b1, 4'd10, acc);
        step(1'b0, 1'b1, 4'd3, acc);
        chk_bit("s2_ready_low", 32'(in_ready), 32'd0);
        idle(3);
        chk_real("s2_launch_val", o_val(out), 1.0, 1e-9);
        chk_real("s2_launch_slope", o_slope(out), -1.75e8, 1.0);
        idle(4);
        chk_real("s2_end_val", o_val(out), 0.3, 1e-9);
        chk_real("s2_end_slope", o_slope(out), 0.0, 1e-12);
        chk_bit("s2_busy_end", 32'(busy), 32'd0);

        // Scenario 3: back-to-back 15, 0, 15 with valid held
        do_reset();
        q = '{4'd15, 4'd0, 4'd15};
        for (int i = 0; i < 13; i++) begin
            if (q.size() > 0) step(1'b0, 1'b1, q[0], acc);
            else              step(1'b0, 1'b0, 4'd0, acc);
            if (acc) void'(q.pop_front());
            if (i < 12) chk_bit("s3_busy", 32'(busy), 32'd1);
            if (i == 4) chk_real("s3_slope_down", o_slope(out), -3.75e8, 1.0);
            if (i == 8) chk_real("s3_slope_up", o_slope(out), 3.75e8, 1.0);
        end
        chk_bit("s3_busy_end", 32'(busy), 32'd0);
        chk_bit("s3_all_sent", 32'(q.size()), 32'd0);
        chk_real("s3_final", o_val(out), 1.5, 1e-9);

        // Scenario 4: reset in the middle of a ramp with a code pending
        do_reset();
        step(1'b0, 1'b1, 4'd15, acc);
        step(1'b0, 1'b1, 4'd7, acc);
        step(1'b1, 1'b0, 4'd0, acc);
        chk_real("s4_val", o_val(out), 0.0, 1e-12);
        chk_real("s4_slope", o_slope(out), 0.0, 1e-12);
        chk_bit("s4_busy", 32'(busy), 32'd0);
        chk_bit("s4_cur", 32'(cur_code), 32'd0);
        idle(6);
        chk_bit("s4_pend_dropped", 32'(cur_code), 32'd0);

        // Scenario 5: clock period stretched to 2 ns while a ramp is in flight
        do_reset();
        step(1'b0, 1'b1, 4'd15, acc);
        step(1'b0, 1'b1, 4'd4, acc);
        half_ns = 1.0;
        step(1'b0, 1'b0, 4'd0, acc);
        chk_real("s5_inflight_slope", o_slope(out), 3.75e8, 1.0);
        idle(2);
        chk_real("s5_new_slope", o_slope(out), -1.375e8, 1.0);
        idle(4);
        chk_real("s5_end_val", o_val(out), 0.4, 1e-9);
        half_ns = 0.5;

        // Scenario 6: code equal to cur_code while idle
        do_reset();
        step(1'b0, 1'b1, 4'd5, acc);
        idle(4);
        step(1'b0, 1'b1, 4'd5, acc);
        chk_bit("s6_busy", 32'(busy), 32'd0);
        chk_real("s6_slope", o_slope(out), 0.0, 1e-12);
        chk_real("s6_val", o_val(out), 0.5, 1e-9);

        // Random traffic with occasional resets and clock-period changes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 4) begin
                case ($urandom_range(2))
                    0:       half_ns = 0.5;
                    1:       half_ns = 0.75;
                    default: half_ns = 1.0;
                endcase
            end
            step(1'($urandom_range(99) < 3), 1'($urandom_range(99) < 60),
                 4'($urandom_range(15)), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
